pc_gen_unit: RTL and testbench

//  Parametrised PC register plus next-PC generator for the pipelined CPU.

---
 rtl/pc_gen_unit.sv | 156 +++++++++++++++
 tb/tb_pc_gen_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// PC register and next-PC generator with stall, exception redirect and IF-flush pulse.
// Optional return-address stack is enabled by defining PC_RAS_EN.
module pc_gen_unit #(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_req,
  input  logic [2:0]       npc_op,
  input  logic             branch_taken,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] npc,
  output logic             redirect,
  output logic             ras_hit
);

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JAL    = 3'b011;
  localparam logic [2:0] OP_JR     = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_VAL   = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] FOUR      = WIDTH'(32'd4);

  logic             advance;
  logic             nonseq;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] reg_target;
  logic [WIDTH-1:0] ret_target;
  logic             unused_low;

  assign advance       = !exc_req && !stall;
  assign pc_plus4      = pc + FOUR;
  assign branch_target = pc_plus4 + {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  assign jump_target   = {pc_plus4[WIDTH-1:28], imm, 2'b00};
  // Register targets are forced word-aligned; the dropped bits are intentionally ignored.
  assign reg_target    = {rs_data[WIDTH-1:2], 2'b00};
  assign unused_low    = ^rs_data[1:0];

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_push;

  // ras_ptr addresses the next free slot; the circular wrap overwrites the oldest entry.
  assign ras_push   = advance && (npc_op == OP_JAL);
  assign ras_hit    = (npc_op == OP_RET) && (ras_cnt != {CNT_W{1'b0}});
  assign ret_target = ras_hit ? ras_mem[ras_ptr - PTR_ONE] : reg_target;

  // RAS pointer and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr <= {PTR_W{1'b0}};
      ras_cnt <= {CNT_W{1'b0}};
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_ONE;
      if (ras_cnt != CNT_FULL) begin
        ras_cnt <= ras_cnt + CNT_ONE;
      end else begin
        ras_cnt <= ras_cnt;
      end
    end else if (advance && ras_hit) begin
      ras_ptr <= ras_ptr - PTR_ONE;
      ras_cnt <= ras_cnt - CNT_ONE;
    end else begin
      ras_ptr <= ras_ptr;
      ras_cnt <= ras_cnt;
    end
  end

  // RAS storage; entries beyond the count are never read
  always_ff @(posedge clk) begin
    if (!rst && ras_push) begin
      ras_mem[ras_ptr] <= pc_plus4;
    end
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;

  assign ras_hit    = 1'b0;
  assign ret_target = reg_target;
`endif

  // Next-PC selection and non-sequential flag
  always_comb begin
    npc    = pc_plus4;
    nonseq = 1'b0;
    case (npc_op)
      OP_PLUS4: begin
        npc    = pc_plus4;
        nonseq = 1'b0;
      end
      OP_BRANCH: begin
        if (branch_taken) begin
          npc    = branch_target;
          nonseq = 1'b1;
        end else begin
          npc    = pc_plus4;
          nonseq = 1'b0;
        end
      end
      OP_JUMP, OP_JAL: begin
        npc    = jump_target;
        nonseq = 1'b1;
      end
      OP_JR: begin
        npc    = reg_target;
        nonseq = 1'b1;
      end
      OP_RET: begin
        npc    = ret_target;
        nonseq = 1'b1;
      end
      default: begin
        npc    = pc_plus4;
        nonseq = 1'b0;
      end
    endcase
  end

  // PC register and one-cycle redirect pulse; exception overrides stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VAL;
      redirect <= 1'b0;
    end else if (exc_req) begin
      pc       <= EXC_VAL;
      redirect <= 1'b1;
    end else if (stall) begin
      pc       <= pc;
      redirect <= 1'b0;
    end else begin
      pc       <= npc;
      redirect <= nonseq;
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed-vector bench for pc_gen_unit: driver pushes expectations, monitor pops and compares.
// RAS vectors are included when PC_RAS_EN is defined.
module tb_pc_gen_unit;

  localparam logic [2:0] PLUS4 = 3'd0;
  localparam logic [2:0] BR    = 3'd1;
  localparam logic [2:0] JMP   = 3'd2;
  localparam logic [2:0] JAL   = 3'd3;
  localparam logic [2:0] JR    = 3'd4;
  localparam logic [2:0] RET   = 3'd5;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        exc_req;
  logic [2:0]  npc_op;
  logic        branch_taken;
  logic [25:0] imm;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        redirect;
  logic        ras_hit;

  pc_gen_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_req(exc_req), .npc_op(npc_op),
    .branch_taken(branch_taken), .imm(imm), .rs_data(rs_data), .pc(pc),
    .pc_plus4(pc_plus4), .npc(npc), .redirect(redirect), .ras_hit(ras_hit)
  );

  typedef struct {
    string       name;
    logic        rst, stall, exc;
    logic [2:0]  op;
    logic        taken;
    logic [25:0] imm;
    logic [31:0] rs;
    logic        chk;
    logic [31:0] pc, npc;
    logic        red, hit;
  } vec_t;

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] pc, npc;
    logic        red, hit;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic v(input string name, input logic r, input logic s, input logic e,
                   input logic [2:0] op, input logic t, input logic [25:0] im, input logic [31:0] rs,
                   input logic [31:0] epc, input logic ered, input logic [31:0] enpc, input logic ehit);
    vec_t x;
    x.name = name; x.rst = r; x.stall = s; x.exc = e; x.op = op; x.taken = t;
    x.imm = im; x.rs = rs; x.chk = 1'b1; x.pc = epc; x.red = ered; x.npc = enpc; x.hit = ehit;
    vecs.push_back(x);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: outputs settle 2 time units after each negedge drive.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          cmp({e.name, ".pc"}, pc, e.pc);
          cmp({e.name, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
          cmp({e.name, ".redirect"}, {31'd0, redirect}, {31'd0, e.red});
          cmp({e.name, ".npc"}, npc, e.npc);
          cmp({e.name, ".ras_hit"}, {31'd0, ras_hit}, {31'd0, e.hit});
        end
      end
    end
  end

  initial begin
    vec_t x;
    exp_t e;
    int   waited;
    rst = 1'b1; stall = 1'b0; exc_req = 1'b0; npc_op = PLUS4;
    branch_taken = 1'b0; imm = 26'd0; rs_data = 32'd0;

    x.name = "rst0"; x.rst = 1'b1; x.stall = 1'b0; x.exc = 1'b0; x.op = PLUS4; x.taken = 1'b0;
    x.imm = 26'd0; x.rs = 32'd0; x.chk = 1'b0; x.pc = 32'd0; x.npc = 32'd0; x.red = 1'b0; x.hit = 1'b0;
    vecs.push_back(x);
    //  name        rst   stall exc   op         tk    imm           rs             pc            red   npc           hit
    v("rst1",      1'b1, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_3000, 1'b0, 32'h0000_3004, 1'b0);
    v("seq0",      1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_3000, 1'b0, 32'h0000_3004, 1'b0);
    v("seq1",      1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_3004, 1'b0, 32'h0000_3008, 1'b0);
    v("op110",     1'b0, 1'b0, 1'b0, 3'b110,    1'b1, 26'h3FF_FFFF, 32'h0,         32'h0000_3008, 1'b0, 32'h0000_300C, 1'b0);
    v("op111",     1'b0, 1'b0, 1'b0, 3'b111,    1'b1, 26'h0,        32'h0,         32'h0000_300C, 1'b0, 32'h0000_3010, 1'b0);
    v("br_tk",     1'b0, 1'b0, 1'b0, BR,        1'b1, 26'h000_FFFF, 32'h0,         32'h0000_3010, 1'b0, 32'h0000_3010, 1'b0);
    v("br_nt",     1'b0, 1'b0, 1'b0, BR,        1'b0, 26'h000_FFFF, 32'h0,         32'h0000_3010, 1'b1, 32'h0000_3014, 1'b0);
    v("rst2",      1'b1, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_3014, 1'b0, 32'h0000_3018, 1'b0);
    v("jump",      1'b0, 1'b0, 1'b0, JMP,       1'b0, 26'h000_0C40, 32'h0,         32'h0000_3000, 1'b0, 32'h0000_3100, 1'b0);
    v("jr",        1'b0, 1'b0, 1'b0, JR,        1'b0, 26'h0,        32'h0000_5007, 32'h0000_3100, 1'b1, 32'h0000_5004, 1'b0);
    v("stall0",    1'b0, 1'b1, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_5004, 1'b1, 32'h0000_5008, 1'b0);
    v("stall1",    1'b0, 1'b1, 1'b0, JMP,       1'b0, 26'h000_0C40, 32'h0,         32'h0000_5004, 1'b0, 32'h0000_3100, 1'b0);
    v("stall2",    1'b0, 1'b1, 1'b0, JR,        1'b0, 26'h0,        32'h0000_5007, 32'h0000_5004, 1'b0, 32'h0000_5004, 1'b0);
    v("stall_exc", 1'b0, 1'b1, 1'b1, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_5004, 1'b0, 32'h0000_5008, 1'b0);
    v("exc_vec",   1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_4180, 1'b1, 32'h0000_4184, 1'b0);
    v("br_fwd",    1'b0, 1'b0, 1'b0, BR,        1'b1, 26'h000_0010, 32'h0,         32'h0000_4184, 1'b0, 32'h0000_41C8, 1'b0);
    v("jal",       1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0800, 32'h0,         32'h0000_41C8, 1'b1, 32'h0000_2000, 1'b0);
    v("rst3",      1'b1, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_2000, 1'b1, 32'h0000_2004, 1'b0);
    v("ret_empty", 1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0000_600B, 32'h0000_3000, 1'b0, 32'h0000_6008, 1'b0);
    v("after_ret", 1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_6008, 1'b1, 32'h0000_600C, 1'b0);
    v("jr_top",    1'b0, 1'b0, 1'b0, JR,        1'b0, 26'h0,        32'hFFFF_FFFC, 32'h0000_600C, 1'b0, 32'hFFFF_FFFC, 1'b0);
    v("wrap",      1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b0);
    v("exc_nost",  1'b0, 1'b0, 1'b1, JMP,       1'b0, 26'h000_0C40, 32'h0,         32'h0000_0000, 1'b0, 32'h0000_3100, 1'b0);
    v("exc_red",   1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_4180, 1'b1, 32'h0000_4184, 1'b0);
    v("jr_hi",     1'b0, 1'b0, 1'b0, JR,        1'b0, 26'h0,        32'h8000_0001, 32'h0000_4184, 1'b0, 32'h8000_0000, 1'b0);
    v("jump_hi",   1'b0, 1'b0, 1'b0, JMP,       1'b0, 26'h3FF_FFFF, 32'h0,         32'h8000_0000, 1'b1, 32'h8FFF_FFFC, 1'b0);
    v("seq_hi",    1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h8FFF_FFFC, 1'b1, 32'h9000_0000, 1'b0);
    v("rst4",      1'b1, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h9000_0000, 1'b0, 32'h9000_0004, 1'b0);
    v("seq_end",   1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_3000, 1'b0, 32'h0000_3004, 1'b0);
`ifdef PC_RAS_EN
    v("r_rst",     1'b1, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_3004, 1'b0, 32'h0000_3008, 1'b0);
    v("r_jal0",    1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0C40, 32'h0,         32'h0000_3000, 1'b0, 32'h0000_3100, 1'b0);
    v("r_jal1",    1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0C80, 32'h0,         32'h0000_3100, 1'b1, 32'h0000_3200, 1'b0);
    v("r_jal2",    1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_1000, 32'h0,         32'h0000_3200, 1'b1, 32'h0000_4000, 1'b0);
    v("r_ret0",    1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0,         32'h0000_4000, 1'b1, 32'h0000_3204, 1'b1);
    v("r_ret1",    1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0,         32'h0000_3204, 1'b1, 32'h0000_3104, 1'b1);
    v("r_ret2",    1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0,         32'h0000_3104, 1'b1, 32'h0000_3004, 1'b1);
    v("r_ret3",    1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0000_7000, 32'h0000_3004, 1'b1, 32'h0000_7000, 1'b0);
    v("r_seq",     1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_7000, 1'b1, 32'h0000_7004, 1'b0);
    v("o_jal0",    1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0C40, 32'h0,         32'h0000_7004, 1'b0, 32'h0000_3100, 1'b0);
    v("o_jal1",    1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0C80, 32'h0,         32'h0000_3100, 1'b1, 32'h0000_3200, 1'b0);
    v("o_jal2",    1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0CC0, 32'h0,         32'h0000_3200, 1'b1, 32'h0000_3300, 1'b0);
    v("o_jal3",    1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0D00, 32'h0,         32'h0000_3300, 1'b1, 32'h0000_3400, 1'b0);
    v("o_jal4",    1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0D40, 32'h0,         32'h0000_3400, 1'b1, 32'h0000_3500, 1'b0);
    v("o_stall",   1'b0, 1'b1, 1'b0, RET,       1'b0, 26'h0,        32'h0,         32'h0000_3500, 1'b1, 32'h0000_3404, 1'b1);
    v("o_exc",     1'b0, 1'b0, 1'b1, RET,       1'b0, 26'h0,        32'h0,         32'h0000_3500, 1'b0, 32'h0000_3404, 1'b1);
    v("o_ret0",    1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0,         32'h0000_4180, 1'b1, 32'h0000_3404, 1'b1);
    v("o_ret1",    1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0,         32'h0000_3404, 1'b1, 32'h0000_3304, 1'b1);
    v("o_ret2",    1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0,         32'h0000_3304, 1'b1, 32'h0000_3204, 1'b1);
    v("o_ret3",    1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0,         32'h0000_3204, 1'b1, 32'h0000_3104, 1'b1);
    v("o_empty",   1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0000_7000, 32'h0000_3104, 1'b1, 32'h0000_7000, 1'b0);
    v("m_jal",     1'b0, 1'b0, 1'b0, JAL,       1'b0, 26'h000_0C40, 32'h0,         32'h0000_7000, 1'b1, 32'h0000_3100, 1'b0);
    v("m_rst",     1'b1, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0000_5555, 32'h0000_3100, 1'b1, 32'h0000_7004, 1'b1);
    v("m_ret",     1'b0, 1'b0, 1'b0, RET,       1'b0, 26'h0,        32'h0000_5555, 32'h0000_3000, 1'b0, 32'h0000_5554, 1'b0);
    v("m_seq",     1'b0, 1'b0, 1'b0, PLUS4,     1'b0, 26'h0,        32'h0,         32'h0000_5554, 1'b1, 32'h0000_5558, 1'b0);
`endif

    // Driver: apply one vector per cycle and queue what the monitor should see.
    foreach (vecs[i]) begin
      @(negedge clk);
      x = vecs[i];
      rst = x.rst; stall = x.stall; exc_req = x.exc; npc_op = x.op;
      branch_taken = x.taken; imm = x.imm; rs_data = x.rs;
      e.name = x.name; e.chk = x.chk; e.pc = x.pc; e.npc = x.npc; e.red = x.red; e.hit = x.hit;
      exp_q.push_back(e);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
